init_sequencer: RTL and testbench



---
 rtl/init_sequencer_pkg.sv | 21 ++
 rtl/init_sequencer_if.sv | 15 +
 rtl/init_sequencer_reset_sync.sv | 17 +
 rtl/init_sequencer.sv | 129 ++++++++++++
 tb/tb_init_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/init_sequencer_pkg.sv
// Shared types and constants for the power-on / soft-reset sequencer.
package init_seq_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_HOLD_CYCLES = 16;
  localparam int unsigned DEF_NUM_DOMAINS = 3;
  localparam int unsigned DEF_STAGE_GAP   = 4;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/init_sequencer_if.sv
// Soft re-init handshake plus the staged reset / status outputs of the sequencer.
interface init_sequencer_if
  import init_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = DEF_NUM_DOMAINS
);
  logic                   soft_req;
  logic                   soft_ack;
  logic [NUM_DOMAINS-1:0] rst_out_n;
  logic                   init_done;
  logic                   busy;

  modport master (output soft_req, input soft_ack, rst_out_n, init_done, busy);
  modport slave  (input soft_req, output soft_ack, rst_out_n, init_done, busy);
endinterface

// File: rtl/init_sequencer_reset_sync.sv
// Async-assert / sync-deassert reset synchroniser, STAGES flops deep.
module reset_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  output logic sync_n
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[STAGES-2:0], 1'b1};
  end

  assign sync_n = chain[STAGES-1];
endmodule

// File: rtl/init_sequencer.sv
// Staged reset release sequencer with software re-init handshake.
module init_sequencer
  import init_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int unsigned STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic           clock,
  input  logic           reset_n,
  init_sequencer_if.slave bus
);
  localparam int unsigned CW = cnt_width((HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP);
  localparam int unsigned IW = cnt_width(NUM_DOMAINS);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("init_sequencer: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("init_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (NUM_DOMAINS < 1) begin : g_chk_dom
    $error("init_sequencer: NUM_DOMAINS must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_chk_gap
    $error("init_sequencer: STAGE_GAP must be >= 1");
  end

  logic sync_n;

  reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .sync_n (sync_n)
  );

  state_t                 state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [IW-1:0]          idx, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   ack_q, ack_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_SYNC;
      cnt    <= '0;
      idx    <= '0;
      rst_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b1;
      ack_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      rst_q  <= rst_d;
      done_q <= done_d;
      busy_q <= busy_d;
      ack_q  <= ack_d;
    end
  end

  // Outputs are computed one cycle ahead so every one leaves a flop.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    rst_d   = rst_q;
    done_d  = done_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    unique case (state)
      ST_SYNC: begin
        if (sync_n) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_d  = ST_RELEASE;
          cnt_d    = '0;
          idx_d    = '0;
          rst_d[0] = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (idx == IDX_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (cnt == GAP_LAST) begin
          idx_d = idx + 1'b1;
          cnt_d = '0;
          for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
            if (i == 32'(idx) + 32'd1) rst_d[i] = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.soft_req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          ack_d   = 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign bus.rst_out_n = rst_q;
  assign bus.init_done = done_q;
  assign bus.busy      = busy_q;
  assign bus.soft_ack  = ack_q;
endmodule

// File: tb/tb_init_sequencer.sv
// Scoreboard bench for init_sequencer: default build plus a minimum-parameter build.
module tb_init_sequencer;

  typedef struct {
    int         e;
    logic [5:0] v;
  } exp_t;

  logic clock = 1'b1;
  logic reset_n = 1'b0;
  logic rn2 = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  exp_t sbq[$];

  always #5 clock = ~clock;

  init_sequencer_if #(.NUM_DOMAINS(3)) bus ();
  init_sequencer_if #(.NUM_DOMAINS(1)) bus2 ();

  init_sequencer #(
    .SYNC_STAGES(2), .HOLD_CYCLES(16), .NUM_DOMAINS(3), .STAGE_GAP(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave)
  );

  init_sequencer #(
    .SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_DOMAINS(1), .STAGE_GAP(1)
  ) dut2 (
    .clock(clock), .reset_n(rn2), .bus(bus2.slave)
  );

  // {rst_out_n, init_done, busy, soft_ack}
  logic [5:0] obs, obs2;
  assign obs  = {bus.rst_out_n, bus.init_done, bus.busy, bus.soft_ack};
  assign obs2 = {2'b00, bus2.rst_out_n, bus2.init_done, bus2.busy, bus2.soft_ack};

  // Expected default-build outputs at edge k for a hold phase entered at edge h.
  function automatic logic [5:0] seq_exp(input int k, input int h, input bit with_ack);
    logic [2:0] r;
    logic       d;
    r[0] = (k >= h + 16);
    r[1] = (k >= h + 20);
    r[2] = (k >= h + 24);
    d    = (k >= h + 25);
    return {r, d, ~d, (with_ack && k == h)};
  endfunction

  function automatic logic [5:0] corner_exp(input int k);
    if (k <= 3) return 6'b00_0_0_1_0;
    if (k == 4) return 6'b00_1_0_1_0;
    if (k <= 6) return 6'b00_1_1_0_0;
    case ((k - 7) % 3)
      0:       return 6'b00_0_0_1_1;
      1:       return 6'b00_1_0_1_0;
      default: return 6'b00_1_1_0_0;
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    edge_cnt++;
  endtask

  task automatic release_main();
    @(negedge clock);
    reset_n  = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic assert_main_reset(input int cycles);
    @(negedge clock);
    reset_n = 1'b0;
    repeat (cycles) step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++;
    if (obs !== 6'b000_0_1_0) begin
      bad++;
      $display("FAIL reset_values got=%b want=%b", obs, 6'b000_0_1_0);
    end
    total++;
    if (obs2 !== 6'b00_0_0_1_0) begin
      bad++;
      $display("FAIL reset_values_corner got=%b want=%b", obs2, 6'b00_0_0_1_0);
    end
  endtask

  task automatic test_power_on();
    for (int k = 1; k <= 35; k++) sbq.push_back('{k, seq_exp(k, 3, 1'b0)});
    release_main();
    while (sbq.size() > 0 && edge_cnt < 40) begin
      step();
      while (sbq.size() > 0 && sbq[0].e == edge_cnt) begin
        exp_t x = sbq.pop_front();
        total++;
        if (obs !== x.v) begin
          bad++;
          $display("FAIL power_on edge=%0d got=%b want=%b", edge_cnt, obs, x.v);
        end
      end
    end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL power_on_timeout pending=%0d want=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_soft_reinit();
    for (int k = 36; k <= 70; k++)
      sbq.push_back('{k, (k < 40) ? seq_exp(k, 3, 1'b0) : seq_exp(k, 40, 1'b1)});
    while (sbq.size() > 0 && edge_cnt < 75) begin
      step();
      while (sbq.size() > 0 && sbq[0].e == edge_cnt) begin
        exp_t x = sbq.pop_front();
        total++;
        if (obs !== x.v) begin
          bad++;
          $display("FAIL soft_reinit edge=%0d got=%b want=%b", edge_cnt, obs, x.v);
        end
      end
      if (edge_cnt == 39) bus.soft_req = 1'b1;
      if (edge_cnt == 40) bus.soft_req = 1'b0;
    end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL soft_reinit_timeout pending=%0d want=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_mid_reset();
    assert_main_reset(2);
    for (int k = 1; k <= 21; k++) sbq.push_back('{k, seq_exp(k, 3, 1'b0)});
    release_main();
    while (sbq.size() > 0 && edge_cnt < 25) begin
      step();
      while (sbq.size() > 0 && sbq[0].e == edge_cnt) begin
        exp_t x = sbq.pop_front();
        total++;
        if (obs !== x.v) begin
          bad++;
          $display("FAIL mid_reset_pre edge=%0d got=%b want=%b", edge_cnt, obs, x.v);
        end
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (obs !== 6'b000_0_1_0) begin
      bad++;
      $display("FAIL mid_reset_async got=%b want=%b", obs, 6'b000_0_1_0);
    end
    repeat (2) step();
    for (int k = 1; k <= 30; k++) sbq.push_back('{k, seq_exp(k, 3, 1'b0)});
    release_main();
    while (sbq.size() > 0 && edge_cnt < 35) begin
      step();
      while (sbq.size() > 0 && sbq[0].e == edge_cnt) begin
        exp_t x = sbq.pop_front();
        total++;
        if (obs !== x.v) begin
          bad++;
          $display("FAIL mid_reset_rerun edge=%0d got=%b want=%b", edge_cnt, obs, x.v);
        end
      end
    end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL mid_reset_timeout pending=%0d want=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_early_req();
    assert_main_reset(2);
    for (int k = 1; k <= 58; k++)
      sbq.push_back('{k, (k <= 28) ? seq_exp(k, 3, 1'b0) : seq_exp(k, 29, 1'b1)});
    release_main();
    while (sbq.size() > 0 && edge_cnt < 65) begin
      step();
      while (sbq.size() > 0 && sbq[0].e == edge_cnt) begin
        exp_t x = sbq.pop_front();
        total++;
        if (obs !== x.v) begin
          bad++;
          $display("FAIL early_req edge=%0d got=%b want=%b", edge_cnt, obs, x.v);
        end
      end
      if (edge_cnt == 9) bus.soft_req = 1'b1;
      if (bus.soft_ack || edge_cnt >= 40) bus.soft_req = 1'b0;
    end
    bus.soft_req = 1'b0;
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL early_req_timeout pending=%0d want=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_corners();
    for (int k = 1; k <= 16; k++) sbq.push_back('{k, corner_exp(k)});
    @(negedge clock);
    rn2      = 1'b1;
    edge_cnt = 0;
    while (sbq.size() > 0 && edge_cnt < 20) begin
      step();
      while (sbq.size() > 0 && sbq[0].e == edge_cnt) begin
        exp_t x = sbq.pop_front();
        total++;
        if (obs2 !== x.v) begin
          bad++;
          $display("FAIL corners edge=%0d got=%b want=%b", edge_cnt, obs2, x.v);
        end
      end
      if (edge_cnt == 6) bus2.soft_req = 1'b1;
    end
    bus2.soft_req = 1'b0;
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL corners_timeout pending=%0d want=0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    bus.soft_req  = 1'b0;
    bus2.soft_req = 1'b0;
    test_reset();
    test_power_on();
    test_soft_reinit();
    test_mid_reset();
    test_early_req();
    test_corners();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
